// File: rtl/game_bcd_timer_pkg.sv
// Shared state encodings, BCD constants and digit helpers for the game round timer.
package game_bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [11:0] BCD_ZERO  = 12'h000;
  localparam logic [3:0]  DIGIT_MAX = 4'd9;

  // Decrement a 3-digit BCD value by one; saturates at 000 so it can never wrap to 999.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != BCD_ZERO) begin
      if (v[3:0] != 4'd0) begin
        r[3:0] = v[3:0] - 4'd1;
      end else begin
        r[3:0] = DIGIT_MAX;
        if (v[7:4] != 4'd0) begin
          r[7:4] = v[7:4] - 4'd1;
        end else begin
          r[7:4]  = DIGIT_MAX;
          r[11:8] = v[11:8] - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_bcd_timer_tick_gen.sv
// Prescaler for the round timer: counts enabled cycles and emits a one-cycle tick on wrap.
module game_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_En,
  input  logic i_Clr,
  output logic o_Tick
);

  localparam int unsigned   CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Only the enable advances the count, so a paused round resumes mid-period.
  always_comb begin
    cnt_d  = cnt_q;
    o_Tick = 1'b0;
    if (i_Clr) begin
      cnt_d = '0;
    end else if (i_En) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        o_Tick = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_bcd_timer.sv
// 3-digit BCD countdown timer for a game round: load, start, pause/resume, expiry flag.
module game_bcd_timer
  import game_bcd_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter logic [11:0] START_VAL = 12'h060
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Load,
  input  logic [11:0] i_LoadVal,
  input  logic        i_Start,
  input  logic        i_Pause,
  output logic [3:0]  o_Bcd0,
  output logic [3:0]  o_Bcd1,
  output logic [3:0]  o_Bcd2,
  output logic        o_Running,
  output logic        o_Expired,
  output logic        o_Done
);

  state_e      state_q, state_d;
  logic [11:0] digits_q, digits_d;
  logic        running_q, running_d;
  logic        expired_q, expired_d;
  logic        done_q, done_d;
  logic        tick;
  logic        tick_en;
  logic        tick_clr;
  logic [11:0] load_clamped;
  logic [11:0] digits_dec;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_clamp
      assign load_clamped[gi*4 +: 4] =
        (i_LoadVal[gi*4 +: 4] > DIGIT_MAX) ? DIGIT_MAX : i_LoadVal[gi*4 +: 4];
    end
  endgenerate

  assign digits_dec = bcd_dec(digits_q);
  assign tick_en    = (state_q == ST_RUN);

  game_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_En   (tick_en),
    .i_Clr  (tick_clr),
    .o_Tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    tick_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Load) begin
          digits_d = load_clamped;
        end else if (i_Start && (digits_q != BCD_ZERO)) begin
          state_d  = ST_RUN;
          tick_clr = 1'b1;
        end
      end
      ST_RUN: begin
        // A decrement coinciding with a pause is still applied before pausing.
        if (tick) begin
          digits_d = digits_dec;
        end
        if (tick && (digits_dec == BCD_ZERO)) begin
          state_d = ST_EXPIRED;
          done_d  = 1'b1;
        end else if (i_Pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (i_Pause) begin
          state_d = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        if (i_Load) begin
          digits_d = load_clamped;
          state_d  = ST_IDLE;
        end else if (i_Start) begin
          digits_d = START_VAL;
          state_d  = ST_RUN;
          tick_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      digits_q  <= START_VAL;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign o_Bcd0    = digits_q[3:0];
  assign o_Bcd1    = digits_q[7:4];
  assign o_Bcd2    = digits_q[11:8];
  assign o_Running = running_q;
  assign o_Expired = expired_q;
  assign o_Done    = done_q;

endmodule

// File: tb/tb_game_bcd_timer.sv
// Scoreboard bench for game_bcd_timer: stimulus queues expected outputs per cycle, a monitor checks them.
module tb_game_bcd_timer;

  localparam int TICK_DIV = 4;
  localparam int K_LOAD   = 0;
  localparam int K_START  = 1;
  localparam int K_PAUSE  = 2;
  localparam int K_RST    = 3;
  localparam int K_LDST   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [11:0] load_val = 12'h000;
  logic [3:0]  bcd0, bcd1, bcd2;
  logic        running, expired, done;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [11:0] bcd;
    logic        run;
    logic        exp;
    logic        dn;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  game_bcd_timer #(
    .TICK_DIV  (TICK_DIV),
    .START_VAL (12'h060)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Load    (load),
    .i_LoadVal (load_val),
    .i_Start   (start),
    .i_Pause   (pause),
    .o_Bcd0    (bcd0),
    .o_Bcd1    (bcd1),
    .o_Bcd2    (bcd2),
    .o_Running (running),
    .o_Expired (expired),
    .o_Done    (done)
  );

  // Monitor: compares every expectation whose cycle has come up, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string t;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (e.cyc != cyc || {bcd2, bcd1, bcd0} !== e.bcd || running !== e.run ||
          expired !== e.exp || done !== e.dn) begin
        errors++;
        $display("FAIL %s cyc=%0d: got bcd=%h run=%b exp=%b done=%b, required cyc=%0d bcd=%h run=%b exp=%b done=%b",
                 t, cyc, {bcd2, bcd1, bcd0}, running, expired, done, e.cyc, e.bcd, e.run, e.exp, e.dn);
      end else begin
        $display("ok   %s cyc=%0d: bcd=%h run=%b exp=%b done=%b",
                 t, cyc, {bcd2, bcd1, bcd0}, running, expired, done);
      end
    end
  end

  task automatic expect_at(input int c, input logic [11:0] b, input logic r,
                           input logic x, input logic d, input string t);
    int   idx;
    exp_t e;
    e.cyc = c;
    e.bcd = b;
    e.run = r;
    e.exp = x;
    e.dn  = d;
    idx   = exp_q.size();
    while (idx > 0 && exp_q[idx-1].cyc > c) idx--;
    exp_q.insert(idx, e);
    tag_q.insert(idx, t);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input int c, input int kind, input logic [11:0] v);
    wait_cyc(c);
    case (kind)
      K_LOAD:  begin load = 1'b1; load_val = v; end
      K_START: start = 1'b1;
      K_PAUSE: pause = 1'b1;
      K_RST:   rst = 1'b1;
      default: begin load = 1'b1; load_val = v; start = 1'b1; end
    endcase
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin : stim
    int b;
    int guard;

    // Reset state
    expect_at(1, 12'h060, 1'b0, 1'b0, 1'b0, "reset");
    expect_at(4, 12'h060, 1'b0, 1'b0, 1'b0, "reset_release");
    wait_cyc(3);
    rst = 1'b0;

    // Start from reset value, two decrements, then reset mid-RUN
    b = cyc + 2;
    expect_at(b + 1,  12'h060, 1'b1, 1'b0, 1'b0, "t1_run");
    expect_at(b + 4,  12'h060, 1'b1, 1'b0, 1'b0, "t1_hold");
    expect_at(b + 5,  12'h059, 1'b1, 1'b0, 1'b0, "t1_dec1");
    expect_at(b + 9,  12'h058, 1'b1, 1'b0, 1'b0, "t1_dec2");
    expect_at(b + 11, 12'h060, 1'b0, 1'b0, 1'b0, "t6_rst");
    expect_at(b + 13, 12'h060, 1'b0, 1'b0, 1'b0, "t6_idle");
    pulse(b, K_START, 12'h000);
    pulse(b + 10, K_RST, 12'h000);
    wait_cyc(b + 14);

    // Double borrow, then pause/resume without losing prescaler phase
    b = cyc + 2;
    expect_at(b + 1,  12'h100, 1'b0, 1'b0, 1'b0, "t2_load");
    expect_at(b + 2,  12'h100, 1'b1, 1'b0, 1'b0, "t2_run");
    expect_at(b + 6,  12'h099, 1'b1, 1'b0, 1'b0, "t2_borrow2");
    expect_at(b + 10, 12'h098, 1'b1, 1'b0, 1'b0, "t2_dec");
    expect_at(b + 12, 12'h098, 1'b0, 1'b0, 1'b0, "t4_paused");
    expect_at(b + 32, 12'h098, 1'b0, 1'b0, 1'b0, "t4_frozen");
    expect_at(b + 33, 12'h098, 1'b1, 1'b0, 1'b0, "t4_resume");
    expect_at(b + 34, 12'h098, 1'b1, 1'b0, 1'b0, "t4_hold");
    expect_at(b + 35, 12'h097, 1'b1, 1'b0, 1'b0, "t4_dec");
    expect_at(b + 37, 12'h060, 1'b0, 1'b0, 1'b0, "t2_rst");
    pulse(b, K_LOAD, 12'h100);
    pulse(b + 1, K_START, 12'h000);
    pulse(b + 11, K_PAUSE, 12'h000);
    pulse(b + 32, K_PAUSE, 12'h000);
    pulse(b + 36, K_RST, 12'h000);
    wait_cyc(b + 38);

    // Expiry: one-cycle done, expired holds, restart from EXPIRED reloads the reset value
    b = cyc + 2;
    expect_at(b + 1,  12'h002, 1'b0, 1'b0, 1'b0, "t3_load");
    expect_at(b + 2,  12'h002, 1'b1, 1'b0, 1'b0, "t3_run");
    expect_at(b + 6,  12'h001, 1'b1, 1'b0, 1'b0, "t3_dec1");
    expect_at(b + 9,  12'h001, 1'b1, 1'b0, 1'b0, "t3_predone");
    expect_at(b + 10, 12'h000, 1'b0, 1'b1, 1'b1, "t3_done");
    expect_at(b + 11, 12'h000, 1'b0, 1'b1, 1'b0, "t3_done_off");
    expect_at(b + 21, 12'h000, 1'b0, 1'b1, 1'b0, "t3_stay");
    expect_at(b + 22, 12'h060, 1'b1, 1'b0, 1'b0, "t3_restart");
    expect_at(b + 26, 12'h059, 1'b1, 1'b0, 1'b0, "t3_restart_dec");
    expect_at(b + 28, 12'h060, 1'b0, 1'b0, 1'b0, "t3_rst");
    pulse(b, K_LOAD, 12'h002);
    pulse(b + 1, K_START, 12'h000);
    pulse(b + 21, K_START, 12'h000);
    pulse(b + 27, K_RST, 12'h000);
    wait_cyc(b + 29);

    // Clamp, load ignored in RUN, pause coincident with tick, start at 000, load beats start
    b = cyc + 2;
    expect_at(b + 1,  12'h299, 1'b0, 1'b0, 1'b0, "t5_clamp");
    expect_at(b + 2,  12'h299, 1'b1, 1'b0, 1'b0, "t5_run");
    expect_at(b + 4,  12'h299, 1'b1, 1'b0, 1'b0, "t5_load_run");
    expect_at(b + 6,  12'h298, 1'b0, 1'b0, 1'b0, "t5_pause_tick");
    expect_at(b + 8,  12'h298, 1'b1, 1'b0, 1'b0, "t5_resume");
    expect_at(b + 12, 12'h297, 1'b1, 1'b0, 1'b0, "t5_resume_dec");
    expect_at(b + 14, 12'h060, 1'b0, 1'b0, 1'b0, "t5_rst");
    expect_at(b + 16, 12'h000, 1'b0, 1'b0, 1'b0, "t5_load0");
    expect_at(b + 17, 12'h000, 1'b0, 1'b0, 1'b0, "t5_start0");
    expect_at(b + 21, 12'h000, 1'b0, 1'b0, 1'b0, "t5_start0_hold");
    expect_at(b + 23, 12'h050, 1'b0, 1'b0, 1'b0, "t5_load_start");
    pulse(b, K_LOAD, 12'h2FA);
    pulse(b + 1, K_START, 12'h000);
    pulse(b + 3, K_LOAD, 12'h123);
    pulse(b + 5, K_PAUSE, 12'h000);
    pulse(b + 7, K_PAUSE, 12'h000);
    pulse(b + 13, K_RST, 12'h000);
    pulse(b + 15, K_LOAD, 12'h000);
    pulse(b + 16, K_START, 12'h000);
    pulse(b + 22, K_LDST, 12'h050);
    wait_cyc(b + 24);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked expectations, required 0", exp_q.size());
      errors += exp_q.size();
      checks += exp_q.size();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "timeout");
  end

endmodule
